// File: rtl/cpu_sequencer.sv
// cpu_sequencer
// Architectural state holder for the 8-bit multi-cycle CPU. Registers the
// control FSM state, program counter, instruction register and zero flag,
// and applies the update requests issued by control_unit each cycle.
// Debug state: sticky halt latch, sticky illegal-state flag, saturating
// retired-instruction counter.
//
// Ports
//   clk         rising-edge clock
//   reset       asynchronous active-low reset
//   run         1: advance every cycle, 0: hold all registers
//   next_state  next FSM state from control_unit
//   pc_we       PC update enable
//   pc_sel      0: PC+1, 1: PC + sign-extended pc_offset
//   pc_offset   two's-complement relative jump offset
//   ir_we       load instr from mem_rdata
//   mem_rdata   instruction memory read data
//   zf_we       load zf from alu_zero
//   alu_zero    ALU result-is-zero
//   halt        halt request from control_unit
//   state       current FSM state
//   instr       instruction register
//   pc          program counter
//   zf          zero flag
//   halted      sticky halt indication
//   err         sticky illegal-state flag
//   retired     completed-instruction count (saturating)
//
// state      | meaning
// FETCH      | read instruction at pc
// DECODE     | decode instr
// EXECUTE    | ALU operation
// MEMORY     | data memory access
// WRITEBACK  | register write
// HALT_STATE | stopped until reset
// 110, 111   | illegal, redirected to FETCH and flagged in err

module cpu_sequencer #(
    parameter int PC_W  = 8,
    parameter int RET_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic [2:0]       next_state,
    input  logic             pc_we,
    input  logic             pc_sel,
    input  logic [3:0]       pc_offset,
    input  logic             ir_we,
    input  logic [7:0]       mem_rdata,
    input  logic             zf_we,
    input  logic             alu_zero,
    input  logic             halt,
    output logic [2:0]       state,
    output logic [7:0]       instr,
    output logic [PC_W-1:0]  pc,
    output logic             zf,
    output logic             halted,
    output logic             err,
    output logic [RET_W-1:0] retired
);

    typedef enum logic [2:0] {
        FETCH      = 3'b000,
        DECODE     = 3'b001,
        EXECUTE    = 3'b010,
        MEMORY     = 3'b011,
        WRITEBACK  = 3'b100,
        HALT_STATE = 3'b101
    } state_t;

    state_t            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [7:0]        instr_q, instr_d;
    logic              zf_q, zf_d;
    logic              halted_q, halted_d;
    logic              err_q, err_d;
    logic [RET_W-1:0]  retired_q, retired_d;

    logic [PC_W-1:0]   pc_step;

    // Offset is sign-extended to the full PC width so that the add wraps
    // modulo 2^PC_W in both directions.
    assign pc_step = pc_sel ? {{(PC_W-4){pc_offset[3]}}, pc_offset}
                            : {{(PC_W-1){1'b0}}, 1'b1};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= FETCH;
            pc_q      <= '0;
            instr_q   <= 8'h00;
            zf_q      <= 1'b0;
            halted_q  <= 1'b0;
            err_q     <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            zf_q      <= zf_d;
            halted_q  <= halted_d;
            err_q     <= err_d;
            retired_q <= retired_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        instr_d   = instr_q;
        zf_d      = zf_q;
        halted_d  = halted_q;
        err_d     = err_q;
        retired_d = retired_q;

        if (run && !halted_q) begin
            // halt request wins over whatever next_state says, including
            // an illegal code, so no error is flagged on a halting edge
            if (halt || next_state == HALT_STATE) begin
                state_d  = HALT_STATE;
                halted_d = 1'b1;
            end else if (next_state > HALT_STATE) begin
                state_d = FETCH;
                err_d   = 1'b1;
            end else begin
                state_d = state_t'(next_state);
            end

            if (pc_we) pc_d    = pc_q + pc_step;
            if (ir_we) instr_d = mem_rdata;
            if (zf_we) zf_d    = alu_zero;

            if (state_q != FETCH && state_d == FETCH && retired_q != {RET_W{1'b1}})
                retired_d = retired_q + 1'b1;
        end
    end

    assign state   = state_q;
    assign pc      = pc_q;
    assign instr   = instr_q;
    assign zf      = zf_q;
    assign halted  = halted_q;
    assign err     = err_q;
    assign retired = retired_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
module tb_cpu_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        run;
    logic [2:0]  next_state;
    logic        pc_we;
    logic        pc_sel;
    logic [3:0]  pc_offset;
    logic        ir_we;
    logic [7:0]  mem_rdata;
    logic        zf_we;
    logic        alu_zero;
    logic        halt;
    logic [2:0]  state;
    logic [7:0]  instr;
    logic [7:0]  pc;
    logic        zf;
    logic        halted;
    logic        err;
    logic [15:0] retired;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model: plain integers, stepped once per rising edge
    int m_state, m_pc, m_instr, m_zf, m_halted, m_err, m_ret;

    cpu_sequencer #(.PC_W(8), .RET_W(16)) dut (
        .clk(clk), .reset(reset), .run(run), .next_state(next_state),
        .pc_we(pc_we), .pc_sel(pc_sel), .pc_offset(pc_offset),
        .ir_we(ir_we), .mem_rdata(mem_rdata), .zf_we(zf_we),
        .alu_zero(alu_zero), .halt(halt), .state(state), .instr(instr),
        .pc(pc), .zf(zf), .halted(halted), .err(err), .retired(retired)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_state = 0; m_pc = 0; m_instr = 0; m_zf = 0;
        m_halted = 0; m_err = 0; m_ret = 0;
    endtask

    task automatic model_edge();
        int old_state;
        int off;
        if (!reset || !run || m_halted != 0) return;
        old_state = m_state;
        if (halt || next_state == 3'd5) begin
            m_state = 5; m_halted = 1;
        end else if (next_state > 3'd5) begin
            m_state = 0; m_err = 1;
        end else begin
            m_state = int'(next_state);
        end
        if (pc_we) begin
            off = pc_sel ? ((pc_offset >= 8) ? int'(pc_offset) - 16 : int'(pc_offset)) : 1;
            m_pc = (m_pc + off + 256) % 256;
        end
        if (ir_we) m_instr = int'(mem_rdata);
        if (zf_we) m_zf = int'(alu_zero);
        if (old_state != 0 && m_state == 0 && m_ret < 65535) m_ret = m_ret + 1;
    endtask

    task automatic idle_inputs();
        run = 1'b1; next_state = 3'd0; pc_we = 1'b0; pc_sel = 1'b0;
        pc_offset = 4'd0; ir_we = 1'b0; mem_rdata = 8'h00; zf_we = 1'b0;
        alu_zero = 1'b0; halt = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b0;
        model_reset();
        #3;
        n_tests++;
        if ({state, pc, instr, zf, halted, err, retired} !== 38'd0) begin
            n_fail++;
            $display("FAIL reset_values: got state=%0d pc=%0h instr=%0h zf=%0b halted=%0b err=%0b ret=%0d, want all zero",
                     state, pc, instr, zf, halted, err, retired);
        end
        @(negedge clk);
        reset = 1'b1;
        run = 1'b0; next_state = 3'd2; pc_we = 1'b1; ir_we = 1'b1; mem_rdata = 8'h3C;
        zf_we = 1'b1; alu_zero = 1'b1;
        repeat (3) step();
        n_tests++;
        if ({state, pc, instr, zf, halted, err, retired} !== 38'd0) begin
            n_fail++;
            $display("FAIL run0_hold: got state=%0d pc=%0h instr=%0h zf=%0b ret=%0d, want all zero",
                     state, pc, instr, zf, retired);
        end
    endtask

    task automatic test_fetch();
        do_reset();
        mem_rdata = 8'hA5; ir_we = 1'b1; pc_we = 1'b1; pc_sel = 1'b0; next_state = 3'd1;
        step();
        n_tests++;
        if (instr !== 8'hA5 || pc !== 8'h01 || state !== 3'd1) begin
            n_fail++;
            $display("FAIL fetch_inc: got instr=%0h pc=%0h state=%0d, want a5 01 1", instr, pc, state);
        end
    endtask

    task automatic test_jump();
        do_reset();
        pc_we = 1'b1; pc_sel = 1'b0; next_state = 3'd0;
        repeat (16) step();
        n_tests++;
        if (pc !== 8'h10) begin
            n_fail++;
            $display("FAIL pc_count16: got pc=%0h want 10", pc);
        end
        pc_sel = 1'b1; pc_offset = 4'hE;
        step();
        n_tests++;
        if (pc !== 8'h0E) begin
            n_fail++;
            $display("FAIL jump_back: got pc=%0h want 0e", pc);
        end
        pc_offset = 4'h7;
        step();
        n_tests++;
        if (pc !== 8'h15) begin
            n_fail++;
            $display("FAIL jump_fwd: got pc=%0h want 15", pc);
        end
        do_reset();
        pc_we = 1'b1; pc_sel = 1'b1; pc_offset = 4'hF;
        step();
        n_tests++;
        if (pc !== 8'hFF) begin
            n_fail++;
            $display("FAIL wrap_down: got pc=%0h want ff", pc);
        end
        pc_sel = 1'b0;
        step();
        n_tests++;
        if (pc !== 8'h00) begin
            n_fail++;
            $display("FAIL wrap_up: got pc=%0h want 00", pc);
        end
    endtask

    task automatic test_retire();
        do_reset();
        next_state = 3'd1; step();
        next_state = 3'd2; zf_we = 1'b1; alu_zero = 1'b1; step();
        zf_we = 1'b0; alu_zero = 1'b0;
        next_state = 3'd4; step();
        n_tests++;
        if (retired !== 16'd0) begin
            n_fail++;
            $display("FAIL retire_early: got retired=%0d want 0", retired);
        end
        next_state = 3'd0; step();
        n_tests++;
        if (zf !== 1'b1 || retired !== 16'd1 || state !== 3'd0) begin
            n_fail++;
            $display("FAIL add_retire: got zf=%0b retired=%0d state=%0d, want 1 1 0", zf, retired, state);
        end
        step();
        n_tests++;
        if (retired !== 16'd1) begin
            n_fail++;
            $display("FAIL fetch_no_retire: got retired=%0d want 1", retired);
        end
    endtask

    task automatic test_halt();
        do_reset();
        next_state = 3'd1; step();
        halt = 1'b1; next_state = 3'd2; pc_we = 1'b1; ir_we = 1'b1; mem_rdata = 8'h5A;
        step();
        n_tests++;
        if (state !== 3'd5 || halted !== 1'b1 || pc !== 8'h01 || instr !== 8'h5A) begin
            n_fail++;
            $display("FAIL halt_entry: got state=%0d halted=%0b pc=%0h instr=%0h, want 5 1 01 5a",
                     state, halted, pc, instr);
        end
        halt = 1'b0; next_state = 3'd0; mem_rdata = 8'h11; zf_we = 1'b1; alu_zero = 1'b1;
        repeat (3) step();
        n_tests++;
        if (state !== 3'd5 || pc !== 8'h01 || instr !== 8'h5A || zf !== 1'b0 || retired !== 16'd0) begin
            n_fail++;
            $display("FAIL halt_frozen: got state=%0d pc=%0h instr=%0h zf=%0b ret=%0d, want 5 01 5a 0 0",
                     state, pc, instr, zf, retired);
        end
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        n_tests++;
        if ({state, pc, instr, zf, halted, err, retired} !== 38'd0) begin
            n_fail++;
            $display("FAIL async_reset: got state=%0d pc=%0h instr=%0h halted=%0b, want all zero",
                     state, pc, instr, halted);
        end
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        idle_inputs();
    endtask

    task automatic test_illegal();
        do_reset();
        next_state = 3'd1; step();
        next_state = 3'd6; step();
        n_tests++;
        if (state !== 3'd0 || err !== 1'b1 || retired !== 16'd1) begin
            n_fail++;
            $display("FAIL illegal_redirect: got state=%0d err=%0b retired=%0d, want 0 1 1", state, err, retired);
        end
        next_state = 3'd1; step();
        next_state = 3'd3; step();
        n_tests++;
        if (err !== 1'b1 || state !== 3'd3) begin
            n_fail++;
            $display("FAIL err_sticky: got err=%0b state=%0d, want 1 3", err, state);
        end
        next_state = 3'd7; halt = 1'b1; step();
        n_tests++;
        if (state !== 3'd5 || halted !== 1'b1) begin
            n_fail++;
            $display("FAIL halt_over_illegal: got state=%0d halted=%0b, want 5 1", state, halted);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 600; i++) begin
            if (m_halted != 0 && $urandom_range(0, 3) == 0) do_reset();
            run        = ($urandom_range(0, 9) != 0);
            next_state = 3'($urandom_range(0, 7));
            pc_we      = 1'($urandom);
            pc_sel     = 1'($urandom);
            pc_offset  = 4'($urandom);
            ir_we      = 1'($urandom);
            mem_rdata  = 8'($urandom);
            zf_we      = 1'($urandom);
            alu_zero   = 1'($urandom);
            halt       = ($urandom_range(0, 39) == 0);
            step();
            n_tests++;
            if (int'(state) != m_state || int'(pc) != m_pc || int'(instr) != m_instr ||
                int'(zf) != m_zf || int'(halted) != m_halted || int'(err) != m_err ||
                int'(retired) != m_ret) begin
                n_fail++;
                $display("FAIL random_cycle%0d: got st=%0d pc=%0h ir=%0h zf=%0b h=%0b e=%0b r=%0d, want st=%0d pc=%0h ir=%0h zf=%0d h=%0d e=%0d r=%0d",
                         i, state, pc, instr, zf, halted, err, retired,
                         m_state, m_pc, m_instr, m_zf, m_halted, m_err, m_ret);
            end
        end
    endtask

    initial begin
        reset = 1'b0;
        idle_inputs();
        @(negedge clk);
        test_reset();
        test_fetch();
        test_jump();
        test_retire();
        test_halt();
        test_illegal();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
